// File: rtl/booth_pkg.sv
// Shared types and widths for the radix-4 Booth sequential multiplier.
//   OP_W    operand width
//   PROD_W  product / accumulator width
//   DIGITS  number of radix-4 Booth digits processed (one per CALC cycle)
package booth_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned PROD_W = 8;
    localparam int unsigned DIGITS = 2;
    localparam int unsigned PP_W   = OP_W + 1;
    localparam int unsigned TRIP_W = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Recoder output: one's-complemented partial product plus the +1 correction bit.
    typedef struct packed {
        logic [PP_W-1:0] pp;
        logic            neg;
    } pp_word_t;

    // Sign-extend a partial product to the accumulator width.
    function automatic logic [PROD_W-1:0] sext_pp(input logic [PP_W-1:0] pp);
        return {{(PROD_W - PP_W){pp[PP_W-1]}}, pp};
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational radix-4 Booth recoder: turns one multiplier triplet and the
// multiplicand into a 5-bit partial-product word plus its negate bit.
//   a     in   OP_W   multiplicand
//   t     in   3      Booth triplet {t2,t1,t0}
//   pp_c  out  struct partial product (one's complement when negative) and neg
module booth_pp_gen
    import booth_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [TRIP_W-1:0] t,
    output pp_word_t          pp_c
);

    logic s;
    logic dbl;
    logic neg;

    // Digit magnitude select: s picks 1*a, dbl picks 2*a, neither gives 0.
    always_comb begin
        s   = t[0] ^ t[1];
        dbl = ~(t[0] ^ t[1]) & (t[1] ^ t[2]);
        neg = t[2];

        pp_c.neg   = neg;
        pp_c.pp[0] = (a[0] & s) ^ neg;
        for (int i = 1; i < int'(OP_W); i++) begin
            pp_c.pp[i] = ((a[i] & s) | (a[i-1] & dbl)) ^ neg;
        end
        pp_c.pp[OP_W] = (a[OP_W-1] & (s | dbl)) ^ neg;
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-4 Booth multiplier, 4x4 signed -> 8-bit signed, one Booth
// digit per cycle with valid/ready handshakes on both sides.
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b signed 4-bit)
//   out_valid / out_ready product handshake (product signed 8-bit)
//   busy                  high whenever not idle
module booth_seq_mult
    import booth_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    localparam logic [1:0] S_IDLE = 2'(IDLE);
    localparam logic [1:0] S_CALC = 2'(CALC);
    localparam logic [1:0] S_DONE = 2'(DONE);

    localparam int unsigned K_W    = $clog2(DIGITS);
    localparam logic [K_W-1:0] LAST_K = K_W'(DIGITS - 1);

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [OP_W-1:0]   a_q;
    logic [OP_W-1:0]   b_q;
    logic [PROD_W-1:0] acc;
    logic [K_W-1:0]    k;

    logic [OP_W:0]       b_ext_c;
    logic [K_W:0]        shamt_c;
    logic [TRIP_W-1:0]   trip_c;
    pp_word_t            ppw_c;
    logic [PROD_W-1:0]   term_c;
    logic [PROD_W-1:0]   acc_sum_c;

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (in_valid)     state_nx = S_CALC;
            S_CALC:  if (k == LAST_K)  state_nx = S_DONE;
            S_DONE:  if (out_ready)    state_nx = S_IDLE;
            default:                   state_nx = S_IDLE;
        endcase
    end

    // State register with status flags registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= (state_nx == S_IDLE);
            out_valid <= (state_nx == S_DONE);
            busy      <= (state_nx != S_IDLE);
        end
    end

    // Triplet k is b_ext[2k+2:2k] where b_ext = {b, 0}; shift weight is 4^k.
    always_comb begin
        b_ext_c   = {b_q, 1'b0};
        shamt_c   = {k, 1'b0};
        trip_c    = b_ext_c[shamt_c +: TRIP_W];
        term_c    = (sext_pp(ppw_c.pp) << shamt_c) + (PROD_W'(ppw_c.neg) << shamt_c);
        acc_sum_c = acc + term_c;
    end

    booth_pp_gen u_pp_gen (
        .a    (a_q),
        .t    (trip_c),
        .pp_c (ppw_c)
    );

    // Operand capture, accumulation and product load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            k       <= '0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q <= a;
                        b_q <= b;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                S_CALC: begin
                    acc <= acc_sum_c;
                    k   <= k + K_W'(1);
                    if (k == LAST_K) product <= acc_sum_c;
                end
                default: ;
            endcase
        end
    end

endmodule
